// File: rtl/branch_predictor_if.sv
// IF/ID-side bundle for the branch predictor: lookup, resolution and statistics.
interface branch_predictor_if #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned GHR_BITS = 6
);
  // IF-stage lookup
  logic [ADDR_W-1:0]   pred_pc;
  logic                pred_taken;
  logic [ADDR_W-1:0]   pred_target;
  logic                pred_hit;
  logic [GHR_BITS-1:0] pred_ghr;

  // ID-stage resolution
  logic                upd_valid;
  logic [ADDR_W-1:0]   upd_pc;
  logic                upd_is_branch;
  logic                upd_is_jump;
  logic                upd_taken;
  logic [ADDR_W-1:0]   upd_target;
  logic                upd_pred_taken;
  logic [ADDR_W-1:0]   upd_pred_target;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                upd_mispredict;

  // Statistics
  logic [31:0]         stat_branches;
  logic [31:0]         stat_mispredicts;

  // Core side: issues lookups and resolutions, consumes predictions.
  modport master (
    output pred_pc,
    input  pred_taken, pred_target, pred_hit, pred_ghr,
    output upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
    output upd_target, upd_pred_taken, upd_pred_target, upd_ghr,
    input  upd_mispredict,
    input  stat_branches, stat_mispredicts
  );

  // Predictor side.
  modport slave (
    input  pred_pc,
    output pred_taken, pred_target, pred_hit, pred_ghr,
    input  upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
    input  upd_target, upd_pred_taken, upd_pred_target, upd_ghr,
    output upd_mispredict,
    output stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus a PHT of saturating
// counters, indexed bimodally (MODE=0) or gshare-style (MODE=1).
module branch_predictor #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned GHR_BITS = 6,
  parameter int unsigned MODE     = 0
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_LSB = IDX_BITS + 2;
  localparam int unsigned TAG_MSB = IDX_BITS + TAG_BITS + 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  // Table state, all flops so a single reset cycle clears everything
  logic [ENTRIES-1:0]  btb_valid;
  logic [ENTRIES-1:0]  btb_jmp;
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [ADDR_W-1:0]   btb_target [ENTRIES];
  logic [CTR_BITS-1:0] pht        [ENTRIES];
  logic [GHR_BITS-1:0] ghr;
  logic [31:0]         stat_branches_q;
  logic [31:0]         stat_mispredicts_q;

  // Lookup / update addressing
  logic [IDX_BITS-1:0] lk_bidx;
  logic [IDX_BITS-1:0] lk_pidx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [IDX_BITS-1:0] up_bidx;
  logic [IDX_BITS-1:0] up_pidx;
  logic [TAG_BITS-1:0] up_tag;

  logic                lk_hit_c;
  logic                lk_taken_c;
  logic [ADDR_W-1:0]   lk_target_c;
  logic                upd_fire_c;
  logic                mispredict_c;
  logic [CTR_BITS-1:0] ctr_cur_c;
  logic [CTR_BITS-1:0] ctr_nxt_c;
  logic [GHR_BITS-1:0] ghr_nxt_c;

  // PC bits outside the index/tag window alias by design
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pred_pc[ADDR_W-1:TAG_MSB+1], bp.pred_pc[1:0],
                            bp.upd_pc[ADDR_W-1:TAG_MSB+1],  bp.upd_pc[1:0],
                            bp.upd_ghr};

  assign lk_bidx = bp.pred_pc[IDX_BITS+1:2];
  assign lk_tag  = bp.pred_pc[TAG_MSB:TAG_LSB];
  assign up_bidx = bp.upd_pc[IDX_BITS+1:2];
  assign up_tag  = bp.upd_pc[TAG_MSB:TAG_LSB];

  // PHT index: plain PC index, or PC index folded with history
  generate
    if (MODE == 1) begin : g_gshare
      assign lk_pidx = lk_bidx ^ IDX_BITS'(ghr);
      assign up_pidx = up_bidx ^ IDX_BITS'(bp.upd_ghr);
    end else begin : g_bimodal
      assign lk_pidx = lk_bidx;
      assign up_pidx = up_bidx;
    end
  endgenerate

  // History shift-in of the resolved branch outcome
  generate
    if (GHR_BITS == 1) begin : g_ghr1
      assign ghr_nxt_c = bp.upd_taken;
    end else begin : g_ghrn
      assign ghr_nxt_c = {ghr[GHR_BITS-2:0], bp.upd_taken};
    end
  endgenerate

  // Combinational lookup from registered tables; no update bypass
  always_comb begin
    lk_hit_c    = 1'b0;
    lk_taken_c  = 1'b0;
    lk_target_c = '0;
    lk_hit_c    = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
    if (lk_hit_c) begin
      lk_taken_c  = btb_jmp[lk_bidx] || pht[lk_pidx][CTR_BITS-1];
      lk_target_c = btb_target[lk_bidx];
    end
  end

  // Resolution qualification and mispredict detection
  always_comb begin
    upd_fire_c   = 1'b0;
    mispredict_c = 1'b0;
    upd_fire_c   = bp.upd_valid && (bp.upd_is_branch || bp.upd_is_jump);
    mispredict_c = upd_fire_c &&
                   ((bp.upd_pred_taken != bp.upd_taken) ||
                    (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));
  end

  // Saturating counter step for the trained PHT entry
  always_comb begin
    ctr_cur_c = pht[up_pidx];
    ctr_nxt_c = ctr_cur_c;
    if (bp.upd_taken) begin
      if (ctr_cur_c != CTR_MAX) ctr_nxt_c = ctr_cur_c + CTR_BITS'(1);
    end else begin
      if (ctr_cur_c != '0) ctr_nxt_c = ctr_cur_c - CTR_BITS'(1);
    end
  end

  // Table, history and statistics update
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid          <= '0;
      btb_jmp            <= '0;
      ghr                <= '0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        pht[i]        <= CTR_INIT;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (upd_fire_c) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (mispredict_c) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      if (bp.upd_is_branch) begin
        pht[up_pidx] <= ctr_nxt_c;
        ghr          <= ghr_nxt_c;
      end
      // Taken resolutions (re)allocate, evicting any aliasing entry
      if (bp.upd_taken) begin
        btb_valid[up_bidx]  <= 1'b1;
        btb_jmp[up_bidx]    <= bp.upd_is_jump;
        btb_tag[up_bidx]    <= up_tag;
        btb_target[up_bidx] <= bp.upd_target;
      end
    end
  end

  assign bp.pred_hit         = lk_hit_c;
  assign bp.pred_taken       = lk_taken_c;
  assign bp.pred_target      = lk_target_c;
  assign bp.pred_ghr         = ghr;
  assign bp.upd_mispredict   = mispredict_c;
  assign bp.stat_branches    = stat_branches_q;
  assign bp.stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: a bimodal and a gshare instance share stimulus; an
// abstract table model predicts each cycle's outputs.
module tb_branch_predictor;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned IDX_BITS = 6;
  localparam int unsigned TAG_BITS = 8;
  localparam int unsigned CTR_BITS = 2;
  localparam int unsigned GHR_BITS = 6;
  localparam int NENT = 1 << IDX_BITS;
  localparam int CMAX = (1 << CTR_BITS) - 1;
  localparam int CINIT = (1 << (CTR_BITS - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(ADDR_W), .GHR_BITS(GHR_BITS)) bif0 ();
  branch_predictor_if #(.ADDR_W(ADDR_W), .GHR_BITS(GHR_BITS)) bif1 ();

  branch_predictor #(.ADDR_W(ADDR_W), .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS),
    .CTR_BITS(CTR_BITS), .GHR_BITS(GHR_BITS), .MODE(0))
    u_bim (.clk(clk), .rst(rst), .bp(bif0));
  branch_predictor #(.ADDR_W(ADDR_W), .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS),
    .CTR_BITS(CTR_BITS), .GHR_BITS(GHR_BITS), .MODE(1))
    u_gsh (.clk(clk), .rst(rst), .bp(bif1));

  int n_checks = 0;
  int n_errors = 0;
  bit drv_active = 1'b0;

  typedef struct {
    int          inst;
    bit          hit;
    bit          taken;
    logic [31:0] tgt;
    int          ghr;
    bit          mp;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;
  exp_t sbq[$];

  // Behavioural model: per instance, arrays of counters and BTB entries
  int          m_pht [2][NENT];
  bit          m_v   [2][NENT];
  int          m_tag [2][NENT];
  logic [31:0] m_tgt [2][NENT];
  bit          m_j   [2][NENT];
  int          m_ghr [2];
  logic [31:0] m_sb  [2];
  logic [31:0] m_sm  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bidx_of(input logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> (2 + IDX_BITS)) % (1 << TAG_BITS));
  endfunction

  function automatic int pidx_of(input int m, input int b, input int g);
    return (m == 1) ? (b ^ g) : b;
  endfunction

  task automatic model_reset(input int m);
    for (int i = 0; i < NENT; i++) begin
      m_pht[m][i] = CINIT;
      m_v[m][i]   = 1'b0;
      m_tag[m][i] = 0;
      m_tgt[m][i] = '0;
      m_j[m][i]   = 1'b0;
    end
    m_ghr[m] = 0;
    m_sb[m]  = '0;
    m_sm[m]  = '0;
  endtask

  task automatic model_predict(input int m, input logic [31:0] pc,
                               output bit hit, output bit taken, output logic [31:0] tgt);
    int b;
    b     = bidx_of(pc);
    hit   = m_v[m][b] && (m_tag[m][b] == tag_of(pc));
    taken = hit && (m_j[m][b] || (m_pht[m][pidx_of(m, b, m_ghr[m])] > CINIT));
    tgt   = hit ? m_tgt[m][b] : 32'h0;
  endtask

  task automatic model_update(input int m, input bit uv, input bit ub, input bit uj,
                              input bit ut, input logic [31:0] upc, input logic [31:0] utgt,
                              input int ug, input bit mp);
    int b;
    int p;
    if (!(uv && (ub || uj))) return;
    m_sb[m] = m_sb[m] + 32'd1;
    if (mp) m_sm[m] = m_sm[m] + 32'd1;
    b = bidx_of(upc);
    if (ub) begin
      p = pidx_of(m, b, ug);
      if (ut) m_pht[m][p] = (m_pht[m][p] < CMAX) ? m_pht[m][p] + 1 : CMAX;
      else    m_pht[m][p] = (m_pht[m][p] > 0) ? m_pht[m][p] - 1 : 0;
      m_ghr[m] = ((m_ghr[m] * 2) + int'(ut)) % (1 << GHR_BITS);
    end
    if (ut) begin
      m_v[m][b]   = 1'b1;
      m_tag[m][b] = tag_of(upc);
      m_tgt[m][b] = utgt;
      m_j[m][b]   = uj;
    end
  endtask

  task automatic drive_inst(input int m, input logic [31:0] lpc, input bit uv, input bit ub,
                            input bit uj, input bit ut, input logic [31:0] upc,
                            input logic [31:0] utgt, input bit pt, input logic [31:0] ptg,
                            input int g);
    if (m == 0) begin
      bif0.pred_pc = lpc; bif0.upd_valid = uv; bif0.upd_is_branch = ub;
      bif0.upd_is_jump = uj; bif0.upd_taken = ut; bif0.upd_pc = upc;
      bif0.upd_target = utgt; bif0.upd_pred_taken = pt; bif0.upd_pred_target = ptg;
      bif0.upd_ghr = GHR_BITS'(g);
    end else begin
      bif1.pred_pc = lpc; bif1.upd_valid = uv; bif1.upd_is_branch = ub;
      bif1.upd_is_jump = uj; bif1.upd_taken = ut; bif1.upd_pc = upc;
      bif1.upd_target = utgt; bif1.upd_pred_taken = pt; bif1.upd_pred_target = ptg;
      bif1.upd_ghr = GHR_BITS'(g);
    end
  endtask

  // One cycle of stimulus; the accompanying prediction comes from the model
  // (as a pipeline would carry it) unless rnd_pred scrambles it.
  task automatic step(input bit r, input logic [31:0] lpc, input bit uv, input bit ub,
                      input bit uj, input bit ut, input logic [31:0] upc,
                      input logic [31:0] utgt, input bit rnd_pred);
    bit ph, pt, h, t, mp;
    logic [31:0] ptg, tg;
    int g;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    for (int m = 0; m < 2; m++) begin
      model_predict(m, upc, ph, pt, ptg);
      if (rnd_pred) begin
        pt  = 1'($urandom_range(0, 1));
        ptg = ($urandom_range(0, 1) == 1) ? utgt : ($urandom & 32'hFFFF_FFFC);
      end
      g = m_ghr[m];
      drive_inst(m, lpc, uv, ub, uj, ut, upc, utgt, pt, ptg, g);
      model_predict(m, lpc, h, t, tg);
      mp = uv && (ub || uj) && ((pt != ut) || (ut && (ptg != utgt)));
      e = '{inst: m, hit: h, taken: t, tgt: tg, ghr: m_ghr[m], mp: mp, sb: m_sb[m], sm: m_sm[m]};
      sbq.push_back(e);
      if (r) model_reset(m);
      else   model_update(m, uv, ub, uj, ut, upc, utgt, g, mp);
    end
    drv_active = 1'b1;
  endtask

  task automatic idle(input logic [31:0] lpc);
    step(1'b0, lpc, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] lpc, input bit ub, input bit uj, input bit ut,
                     input logic [31:0] upc, input logic [31:0] utgt);
    step(1'b0, lpc, 1'b1, ub, uj, ut, upc, utgt, 1'b0);
  endtask

  // Monitor: pops one expectation per instance per driven cycle
  always @(negedge clk) begin
    exp_t e;
    logic a_hit, a_taken, a_mp;
    logic [31:0] a_tgt, a_sb, a_sm, a_ghr;
    if (drv_active) begin
      for (int k = 0; k < 2; k++) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard_underflow: got 0 entries expected 1 at %0t", $time);
        end else begin
          e = sbq.pop_front();
          if (e.inst == 0) begin
            a_hit = bif0.pred_hit; a_taken = bif0.pred_taken; a_tgt = bif0.pred_target;
            a_ghr = 32'(bif0.pred_ghr); a_mp = bif0.upd_mispredict;
            a_sb = bif0.stat_branches; a_sm = bif0.stat_mispredicts;
          end else begin
            a_hit = bif1.pred_hit; a_taken = bif1.pred_taken; a_tgt = bif1.pred_target;
            a_ghr = 32'(bif1.pred_ghr); a_mp = bif1.upd_mispredict;
            a_sb = bif1.stat_branches; a_sm = bif1.stat_mispredicts;
          end
          chk($sformatf("u%0d.pred_hit", e.inst),    32'(a_hit),   32'(e.hit));
          chk($sformatf("u%0d.pred_taken", e.inst),  32'(a_taken), 32'(e.taken));
          chk($sformatf("u%0d.pred_target", e.inst), a_tgt,        e.tgt);
          chk($sformatf("u%0d.pred_ghr", e.inst),    a_ghr,        32'(e.ghr));
          chk($sformatf("u%0d.upd_mispredict", e.inst), 32'(a_mp), 32'(e.mp));
          chk($sformatf("u%0d.stat_branches", e.inst),    a_sb,    e.sb);
          chk($sformatf("u%0d.stat_mispredicts", e.inst), a_sm,    e.sm);
        end
      end
    end
  end

  logic [31:0] pool [12];
  logic [31:0] mp_base;

  initial begin
    for (int m = 0; m < 2; m++) drive_inst(m, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0);
    repeat (2) @(posedge clk);
    for (int m = 0; m < 2; m++) model_reset(m);

    // Post-reset lookup
    idle(32'h40); #1;
    chk("reset.hit", 32'(bif0.pred_hit), 32'd0);
    chk("reset.taken", 32'(bif0.pred_taken), 32'd0);
    chk("reset.target", bif0.pred_target, 32'h0);
    chk("reset.stat_branches", bif0.stat_branches, 32'd0);

    // First taken branch mispredicts and allocates
    upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 32'h20); #1;
    chk("train.mispredict", 32'(bif0.upd_mispredict), 32'd1);
    idle(32'h40); #1;
    chk("train.hit", 32'(bif0.pred_hit), 32'd1);
    chk("train.target", bif0.pred_target, 32'h20);
    chk("train.taken", 32'(bif0.pred_taken), 32'd1);
    chk("train.stat_mispredicts", bif0.stat_mispredicts, 32'd1);

    // Saturation: 3 stays 3, then two not-taken steps down to 1
    repeat (5) upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 32'h20);
    upd(32'h40, 1'b1, 1'b0, 1'b0, 32'h40, 32'h20);
    idle(32'h40); #1;
    chk("sat.one_nt_taken", 32'(bif0.pred_taken), 32'd1);
    upd(32'h40, 1'b1, 1'b0, 1'b0, 32'h40, 32'h20);
    idle(32'h40); #1;
    chk("sat.two_nt_taken", 32'(bif0.pred_taken), 32'd0);
    chk("sat.two_nt_hit", 32'(bif0.pred_hit), 32'd1);

    // Jump: taken next cycle, history untouched
    upd(32'h80, 1'b0, 1'b1, 1'b1, 32'h80, 32'h100);
    idle(32'h80); #1;
    chk("jump.taken", 32'(bif1.pred_taken), 32'd1);
    chk("jump.target", bif1.pred_target, 32'h100);
    chk("jump.ghr", 32'(bif1.pred_ghr), 32'(m_ghr[1]));

    // Aliasing eviction, then same-cycle lookup sees the old entry
    upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h40 + 32'(4 * NENT), 32'h300);
    idle(32'h40); #1;
    chk("alias.miss", 32'(bif0.pred_hit), 32'd0);
    upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 32'h20); #1;
    chk("same_cycle.old", 32'(bif0.pred_hit), 32'd0);
    idle(32'h40); #1;
    chk("same_cycle.new_hit", 32'(bif0.pred_hit), 32'd1);
    chk("same_cycle.new_target", bif0.pred_target, 32'h20);

    // gshare learns an alternating pattern
    step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    mp_base = '0;
    for (int i = 0; i < 16; i++) begin
      upd(32'h200, 1'b1, 1'b0, (i % 2) == 0, 32'h200, 32'h400);
      if (i == 8) begin #1; mp_base = bif1.stat_mispredicts; end
    end
    idle(32'h200); #1;
    chk("gshare.late_mispredicts", bif1.stat_mispredicts - mp_base, 32'd0);
    chk("gshare.ghr", 32'(bif1.pred_ghr), 32'h2A);

    // Reset mid-sequence, with a resolution that must be ignored
    for (int i = 0; i < 4; i++) upd(32'h200, 1'b1, 1'b0, (i % 2) == 0, 32'h200, 32'h400);
    step(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h400, 1'b0);
    idle(32'h200); #1;
    chk("midrst.hit", 32'(bif1.pred_hit), 32'd0);
    chk("midrst.ghr", 32'(bif1.pred_ghr), 32'd0);
    chk("midrst.stat_branches", bif1.stat_branches, 32'd0);
    chk("midrst.stat_mispredicts", bif0.stat_mispredicts, 32'd0);

    // Random traffic over a small PC pool so entries hit and alias
    for (int i = 0; i < 12; i++)
      pool[i] = (32'(i % 3 == 2 ? 8'h55 : (i % 3)) << (2 + IDX_BITS)) |
                (32'((i * 13) % NENT) << 2) | (32'(i % 2) << 20);
    for (int n = 0; n < 800; n++) begin
      logic [31:0] lpc, upc, utgt;
      bit r, uv, ub, uj, ut;
      int kind;
      lpc  = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(0, 11)];
      upc  = ($urandom_range(0, 3) == 0) ? lpc : pool[$urandom_range(0, 11)];
      utgt = ($urandom_range(0, 1) == 1) ? (32'($urandom_range(0, 7)) << 4) : ($urandom & 32'hFFFF_FFFC);
      r    = ($urandom_range(0, 99) == 0);
      uv   = ($urandom_range(0, 9) < 7);
      kind = $urandom_range(0, 9);
      ub   = (kind < 6);
      uj   = (kind >= 6 && kind < 8);
      ut   = uj ? 1'b1 : 1'($urandom_range(0, 1));
      step(r, lpc, uv, ub, uj, ut, upc, utgt, $urandom_range(0, 3) == 0);
    end
    idle(32'h0);

    @(negedge clk);
    #1;
    drv_active = 1'b0;
    chk("scoreboard.drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor and branch target buffer (BTB) for the pipelined MIPS core.
- Replaces the static "predict PC+4, flush on taken" policy: the IF stage looks up `pred_pc` and gets a taken/target guess the same cycle.
- The ID stage reports each resolved branch or jump through the update port. The block trains its tables and flags mispredicts so the core can flush.
- Supports a bimodal mode and a gshare mode, with configurable table depth and counter width.

Parameters:
- ADDR_W, 32, PC width.
- IDX_BITS, 6, log2 of entry count (PHT and BTB each have 2^IDX_BITS entries).
- TAG_BITS, 8, BTB tag width.
- CTR_BITS, 2, saturating counter width (range 1..4).
- GHR_BITS, 6, global history width (range 1..IDX_BITS).
- MODE, 0, 0 = bimodal, 1 = gshare.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pred_pc  in  ADDR_W  IF-stage PC
- pred_taken  out  1  predict redirect
- pred_target  out  ADDR_W  predicted next PC when pred_taken=1
- pred_hit  out  1  BTB valid and tag match
- pred_ghr  out  GHR_BITS  history snapshot, carried down the pipe
- upd_valid  in  1  resolution strobe, one cycle
- upd_pc  in  ADDR_W  PC of the resolved instruction
- upd_is_branch  in  1  conditional branch (beq/bne)
- upd_is_jump  in  1  unconditional direct jump (j/jal)
- upd_taken  in  1  actual outcome
- upd_target  in  ADDR_W  actual target
- upd_pred_taken  in  1  pred_taken that accompanied this instruction
- upd_pred_target  in  ADDR_W  pred_target that accompanied this instruction
- upd_ghr  in  GHR_BITS  pred_ghr that accompanied this instruction
- upd_mispredict  out  1  combinational mispredict flag
- stat_branches  out  32  resolved control-instruction count
- stat_mispredicts  out  32  mispredict count

Behaviour:
- Reset: synchronous, active-high; `clk` and `rst` as named above.
  - All BTB valid bits clear; every PHT counter = 2^(CTR_BITS-1)-1 (weakly not-taken); GHR = 0; both stat counters = 0.
  - All tables are flops and clear in the single reset cycle, with no sweep.
  - Updates asserted during reset are ignored.
  - Outputs after reset: pred_taken=0, pred_hit=0, pred_target=0, pred_ghr=0.
- Indexing, with pc word-aligned:
  - bidx = pc[IDX_BITS+1:2]
  - tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]
  - pidx = bidx when MODE=0.
  - pidx = bidx XOR zero-extended GHR when MODE=1. Lookup uses the current GHR; update uses upd_ghr.
- Lookup is purely combinational from registered state:
  - pred_hit = valid[bidx] && tag match.
  - pred_taken = pred_hit && (jmp[bidx] || PHT[pidx] MSB).
  - pred_target = btb_target[bidx] when pred_hit, else 0.
  - pred_ghr = GHR.
- Update: applies at the clk edge when upd_valid && (upd_is_branch || upd_is_jump). upd_valid with neither set is a no-op.
  - Branch: PHT[pidx] increments if taken, else decrements, saturating at 0 and 2^CTR_BITS-1.
  - Branch: GHR <= {GHR[GHR_BITS-2:0], upd_taken}; for GHR_BITS=1, GHR <= upd_taken.
  - Jump: PHT and GHR are untouched.
  - BTB write when upd_taken=1: valid=1, tag, target=upd_target, jmp=upd_is_jump. This overwrites any aliasing entry.
  - BTB when not taken: a hit entry keeps its target; a miss allocates nothing.
- upd_mispredict = upd_valid && (upd_is_branch||upd_is_jump) && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)).
- Stats:
  - stat_branches increments by 1 per qualifying update.
  - stat_mispredicts increments by 1 when upd_mispredict.
  - Both wrap modulo 2^32.
- Same-cycle lookup and update on the same index: lookup returns the pre-update value. There is no bypass; the new value is visible the next cycle.
- Both indices must stay within the table bounds; pc bits above the tag are ignored, so aliasing is expected.

Test Plan:
- Reset then lookup pred_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0; stats 0.
- MODE=0: update branch pc=0x40 taken target=0x20, pred_taken=0 -> upd_mispredict=1 that cycle. Next cycle lookup 0x40 -> pred_hit=1, target=0x20, pred_taken=1 (counter 1->2). stat_mispredicts=1.
- Saturation, CTR_BITS=2: 5 taken updates then 1 not-taken at 0x40 -> pred_taken stays 1 (3->2). A second not-taken -> pred_taken=0. Counter never wraps past 3 or below 0.
- Jump pc=0x80 target=0x100 -> pred_taken=1 immediately next cycle regardless of counter; GHR unchanged.
- Aliasing: train 0x40, then a taken update at 0x40+4*2^IDX_BITS with target 0x300 -> lookup 0x40 misses (tag mismatch). Same-cycle lookup and update at 0x40 returns the old entry.
- MODE=1, alternating T/N at one pc for 16 updates with upd_ghr fed from pred_ghr -> mispredicts stop after warm-up. Asserting rst mid-sequence -> all state cleared next cycle.
